// File: rtl/hex_scroll_feeder_pkg.sv
// Shared display defines for the HEX message scroller.
//   CHAR_W / BLANK_CODE : character code width and the all-off code
//   NUM_DIGITS          : digits on the seven-segment bank
//   MSG_LEN_DEF / TICK_DIV_DEF : default ring length and scroll divider
//   scroll_state_e      : scroller FSM encodings
//   ring_idx()          : wrap a pointer sum back into the ring
package hex_scroll_feeder_pkg;

   localparam int CHAR_W       = 5;
   localparam int NUM_DIGITS   = 6;
   localparam logic [CHAR_W-1:0] BLANK_CODE = 5'b11111;
   localparam int MSG_LEN_DEF  = 18;
   localparam int TICK_DIV_DEF = 12500000;

   typedef enum logic [1:0] {
      ST_BLANK  = 2'd0,
      ST_SCROLL = 2'd1,
      ST_PAUSED = 2'd2
   } scroll_state_e;

   // Sum is at most (len-1)+(NUM_DIGITS-1) < 2*len, so one subtract suffices.
   function automatic logic [4:0] ring_idx(input logic [5:0] sum, input logic [5:0] len);
      logic [5:0] r;
      r = (sum >= len) ? (sum - len) : sum;
      return r[4:0];
   endfunction

endpackage

// File: rtl/hex_scroll_feeder_if.sv
// Message buffer write port.
//   wr_en   : write strobe
//   wr_addr : buffer index (indices >= MSG_LEN are dropped)
//   wr_data : character code
interface hex_scroll_feeder_if;
   import hex_scroll_feeder_pkg::*;

   logic              wr_en;
   logic [4:0]        wr_addr;
   logic [CHAR_W-1:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/hex_scroll_feeder_tick.sv
// Scroll-rate divider: counts 0..TICK_DIV-1 and flags the terminal cycle.
//   CLOCK_50 / reset : clock, synchronous active-high reset
//   hold             : freeze the count
//   clear            : force the count to 0 (wins over hold)
//   step             : high during the cycle the count wraps to 0
module scroll_tick_gen
   import hex_scroll_feeder_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic hold,
   input  logic clear,
   output logic step
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      step  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (!hold) begin
         if (cnt_q == CNT_TC) begin
            cnt_d = '0;
            step  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hex_scroll_feeder.sv
// Six-digit scrolling message source for the charToHex digit bank.
//   CLOCK_50 / reset : clock, synchronous active-high reset
//   enable / pause   : show+scroll / freeze scrolling
//   wr               : message buffer write port
//   display          : enable to all charToHex instances
//   char5..char0     : codes for hex5 (leftmost) .. hex0
//   pos / wrap       : rotation pointer, pulse on pointer wrap to 0
//
// state  | meaning
// BLANK  | digits off, divider cleared, pointer held
// SCROLL | divider running, pointer advances on each step
// PAUSED | divider and pointer frozen, digits lit
module hex_scroll_feeder
   import hex_scroll_feeder_pkg::*;
#(
   parameter int MSG_LEN  = MSG_LEN_DEF,
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   pause,
   hex_scroll_feeder_if.slave     wr,
   output logic                   display,
   output logic [CHAR_W-1:0]      char0,
   output logic [CHAR_W-1:0]      char1,
   output logic [CHAR_W-1:0]      char2,
   output logic [CHAR_W-1:0]      char3,
   output logic [CHAR_W-1:0]      char4,
   output logic [CHAR_W-1:0]      char5,
   output logic [4:0]             pos,
   output logic                   wrap
);

   localparam logic [5:0] LEN6     = 6'(MSG_LEN);
   localparam logic [4:0] LEN5     = 5'(MSG_LEN);
   localparam logic [4:0] LAST_POS = 5'(MSG_LEN - 1);

   function automatic logic [MSG_LEN*CHAR_W-1:0] default_msg();
      logic [MSG_LEN*CHAR_W-1:0] r;
      r = '0;
      for (int i = 0; i < MSG_LEN; i++) r[i*CHAR_W +: CHAR_W] = CHAR_W'(MSG_LEN - 1 - i);
      return r;
   endfunction

   localparam logic [MSG_LEN*CHAR_W-1:0] DEFAULT_MSG = default_msg();

   // The buffer stores each entry XOR its default character, so the all-zero
   // power-up state of the flops reads back as the default message without
   // any reset or init pattern; reset leaves it untouched.
   logic [CHAR_W-1:0] msg_delta_q [MSG_LEN];
   logic [CHAR_W-1:0] msg_rd      [MSG_LEN];
   logic              wr_hit;

   assign wr_hit = wr.wr_en && (wr.wr_addr < LEN5);

   always_ff @(posedge CLOCK_50) begin
      if (wr_hit)
         msg_delta_q[wr.wr_addr] <= wr.wr_data ^ DEFAULT_MSG[wr.wr_addr*CHAR_W +: CHAR_W];
   end

   always_comb begin
      for (int i = 0; i < MSG_LEN; i++)
         msg_rd[i] = msg_delta_q[i] ^ DEFAULT_MSG[i*CHAR_W +: CHAR_W];
   end

   scroll_state_e                       state_q, state_d;
   logic [4:0]                          pos_q, pos_d;
   logic                                wrap_q, wrap_d;
   logic                                display_q, display_d;
   logic [NUM_DIGITS-1:0][CHAR_W-1:0]   chars_q, chars_d;
   logic                                step, tick_hold, tick_clear;

   // Disabling clears the divider on the same edge, so no step can land
   // while the FSM is heading into BLANK.
   assign tick_clear = !enable || (state_q == ST_BLANK);
   assign tick_hold  = (state_q != ST_SCROLL);

   scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .hold     (tick_hold),
      .clear    (tick_clear),
      .step     (step)
   );

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      if (!enable) begin
         state_d = ST_BLANK;
      end else begin
         case (state_q)
            ST_BLANK: begin
               state_d = ST_SCROLL;
               pos_d   = '0;
            end
            ST_SCROLL: begin
               if (step) pos_d = (pos_q == LAST_POS) ? 5'd0 : pos_q + 5'd1;
               if (pause) state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
               if (!pause) state_d = ST_SCROLL;
            end
            default: state_d = ST_BLANK;
         endcase
      end

      wrap_d    = step && (pos_q == LAST_POS);
      display_d = (state_q != ST_BLANK);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         chars_d[NUM_DIGITS-1-k] = (state_q == ST_BLANK) ? BLANK_CODE
                                 : msg_rd[ring_idx({1'b0, pos_q} + 6'(k), LEN6)];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= ST_BLANK;
         pos_q     <= '0;
         wrap_q    <= 1'b0;
         display_q <= 1'b0;
         chars_q   <= {NUM_DIGITS{BLANK_CODE}};
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         wrap_q    <= wrap_d;
         display_q <= display_d;
         chars_q   <= chars_d;
      end
   end

   assign display = display_q;
   assign wrap    = wrap_q;
   assign pos     = pos_q;
   assign char0   = chars_q[0];
   assign char1   = chars_q[1];
   assign char2   = chars_q[2];
   assign char3   = chars_q[3];
   assign char4   = chars_q[4];
   assign char5   = chars_q[5];

endmodule
